// File: rtl/sky130_fd_io__sio_pair_ctrl.sv
// rtl/sky130_fd_io__sio_pair_ctrl.sv - two-pad SIO controller: hold-protected config, pad output registers, input synchronisers
module sky130_fd_io__sio_pair_ctrl #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CFG_VALID,
    output logic       CFG_READY,
    input  logic       CFG_SEL,
    input  logic [2:0] CFG_DM,
    input  logic       CFG_VTRIP_SEL,
    input  logic       CFG_IBUF_SEL,
    input  logic       CFG_VREG_EN,
    input  logic       CFG_SLOW,
    input  logic       CFG_INP_DIS,
    input  logic       CFG_HLD_OVR,
    output logic       CFG_DONE,
    input  logic [1:0] CORE_OUT,
    input  logic [1:0] CORE_OE,
    input  logic [1:0] IN,
    output logic [1:0] IN_SYNC,
    output logic [1:0] IN_RISE,
    output logic [1:0] IN_FALL,
    output logic [2:0] DM0,
    output logic [2:0] DM1,
    output logic [1:0] OUT,
    output logic [1:0] OE_N,
    output logic [1:0] HLD_H_N,
    output logic [1:0] HLD_OVR,
    output logic [1:0] VTRIP_SEL,
    output logic [1:0] IBUF_SEL,
    output logic [1:0] VREG_EN,
    output logic [1:0] SLOW,
    output logic [1:0] INP_DIS
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_APPLY,
        ST_SETTLE,
        ST_RELEASE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    logic       sh_sel;
    logic [2:0] sh_dm;
    logic       sh_vtrip_sel;
    logic       sh_ibuf_sel;
    logic       sh_vreg_en;
    logic       sh_slow;
    logic       sh_inp_dis;
    logic       sh_hld_ovr;

    logic [1:0] in_s1;
    logic [1:0] in_prev;

    logic       handshake;
    logic       win_cur;
    logic       win_next;
    logic [1:0] sel_mask;
    logic [1:0] hold_mask;
    logic [1:0] freeze_mask;

    assign CFG_READY   = (state == ST_IDLE);
    assign handshake   = CFG_VALID && CFG_READY;
    assign win_cur     = (state == ST_HOLD) || (state == ST_APPLY) || (state == ST_SETTLE);
    assign win_next    = (state_next == ST_HOLD) || (state_next == ST_APPLY) || (state_next == ST_SETTLE);
    assign sel_mask    = sh_sel ? 2'b10 : 2'b01;
    // Hold drops one cycle after entry and lifts on the edge that enters RELEASE
    assign hold_mask   = (win_cur && win_next) ? sel_mask : 2'b00;
    assign freeze_mask = win_cur ? sel_mask : 2'b00;

    // HOLD is loaded with HOLD_CYCLES (not -1): its first cycle is spent getting hold onto the pad
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
        case (state)
            ST_IDLE: begin
                if (CFG_VALID) begin
                    state_next = ST_HOLD;
                    cnt_next   = 8'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) state_next = ST_APPLY;
            end
            ST_APPLY: begin
                state_next = ST_SETTLE;
                cnt_next   = 8'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (cnt == 8'd0) state_next = ST_RELEASE;
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            sh_sel       <= 1'b0;
            sh_dm        <= 3'b000;
            sh_vtrip_sel <= 1'b0;
            sh_ibuf_sel  <= 1'b0;
            sh_vreg_en   <= 1'b0;
            sh_slow      <= 1'b0;
            sh_inp_dis   <= 1'b0;
            sh_hld_ovr   <= 1'b0;
            CFG_DONE     <= 1'b0;
            HLD_H_N      <= 2'b11;
            OUT          <= 2'b00;
            OE_N         <= 2'b11;
            DM0          <= 3'b000;
            DM1          <= 3'b000;
            HLD_OVR      <= 2'b00;
            VTRIP_SEL    <= 2'b00;
            IBUF_SEL     <= 2'b00;
            VREG_EN      <= 2'b00;
            SLOW         <= 2'b00;
            INP_DIS      <= 2'b11;
            in_s1        <= 2'b00;
            IN_SYNC      <= 2'b00;
            in_prev      <= 2'b00;
            IN_RISE      <= 2'b00;
            IN_FALL      <= 2'b00;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            CFG_DONE <= (state_next == ST_RELEASE);
            HLD_H_N  <= ~hold_mask;

            if (handshake) begin
                sh_sel       <= CFG_SEL;
                sh_dm        <= CFG_DM;
                sh_vtrip_sel <= CFG_VTRIP_SEL;
                sh_ibuf_sel  <= CFG_IBUF_SEL;
                sh_vreg_en   <= CFG_VREG_EN;
                sh_slow      <= CFG_SLOW;
                sh_inp_dis   <= CFG_INP_DIS;
                sh_hld_ovr   <= CFG_HLD_OVR;
            end

            if (state == ST_APPLY) begin
                if (sh_sel) DM1 <= sh_dm;
                else        DM0 <= sh_dm;
                VTRIP_SEL[sh_sel] <= sh_vtrip_sel;
                IBUF_SEL[sh_sel]  <= sh_ibuf_sel;
                VREG_EN[sh_sel]   <= sh_vreg_en;
                SLOW[sh_sel]      <= sh_slow;
                INP_DIS[sh_sel]   <= sh_inp_dis;
                HLD_OVR[sh_sel]   <= sh_hld_ovr;
            end

            OUT  <= (OUT & freeze_mask) | (CORE_OUT & ~freeze_mask);
            OE_N <= (OE_N & freeze_mask) | (~CORE_OE & ~freeze_mask);

            // A disabled input buffer flushes its whole synchroniser so re-enabling never fakes an edge
            in_s1   <= IN & ~INP_DIS;
            IN_SYNC <= in_s1 & ~INP_DIS;
            in_prev <= IN_SYNC & ~INP_DIS;
            IN_RISE <= IN_SYNC & ~in_prev & ~INP_DIS;
            IN_FALL <= ~IN_SYNC & in_prev & ~INP_DIS;
        end
    end

endmodule

// File: tb/tb_sky130_fd_io__sio_pair_ctrl.sv
// tb/tb_sky130_fd_io__sio_pair_ctrl.sv - directed self-checking bench for sky130_fd_io__sio_pair_ctrl
module tb_sky130_fd_io__sio_pair_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_sel;
    logic [2:0] cfg_dm;
    logic       cfg_vtrip_sel, cfg_ibuf_sel, cfg_vreg_en, cfg_slow, cfg_inp_dis, cfg_hld_ovr;
    logic [1:0] core_out, core_oe, in_pad;

    logic       cfg_ready, cfg_done;
    logic [1:0] in_sync, in_rise, in_fall, out, oe_n, hld_h_n;
    logic [1:0] hld_ovr, vtrip_sel, ibuf_sel, vreg_en, slow, inp_dis;
    logic [2:0] dm0, dm1;

    logic       b_cfg_ready, b_cfg_done;
    logic [1:0] b_in_sync, b_in_rise, b_in_fall, b_out, b_oe_n, b_hld_h_n;
    logic [1:0] b_hld_ovr, b_vtrip_sel, b_ibuf_sel, b_vreg_en, b_slow, b_inp_dis;
    logic [2:0] b_dm0, b_dm1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sky130_fd_io__sio_pair_ctrl dut (
        .CLK(clk), .RESET(reset), .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
        .CFG_SEL(cfg_sel), .CFG_DM(cfg_dm), .CFG_VTRIP_SEL(cfg_vtrip_sel),
        .CFG_IBUF_SEL(cfg_ibuf_sel), .CFG_VREG_EN(cfg_vreg_en), .CFG_SLOW(cfg_slow),
        .CFG_INP_DIS(cfg_inp_dis), .CFG_HLD_OVR(cfg_hld_ovr), .CFG_DONE(cfg_done),
        .CORE_OUT(core_out), .CORE_OE(core_oe), .IN(in_pad), .IN_SYNC(in_sync),
        .IN_RISE(in_rise), .IN_FALL(in_fall), .DM0(dm0), .DM1(dm1), .OUT(out),
        .OE_N(oe_n), .HLD_H_N(hld_h_n), .HLD_OVR(hld_ovr), .VTRIP_SEL(vtrip_sel),
        .IBUF_SEL(ibuf_sel), .VREG_EN(vreg_en), .SLOW(slow), .INP_DIS(inp_dis)
    );

    sky130_fd_io__sio_pair_ctrl #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1)) dut_b (
        .CLK(clk), .RESET(reset), .CFG_VALID(cfg_valid), .CFG_READY(b_cfg_ready),
        .CFG_SEL(cfg_sel), .CFG_DM(cfg_dm), .CFG_VTRIP_SEL(cfg_vtrip_sel),
        .CFG_IBUF_SEL(cfg_ibuf_sel), .CFG_VREG_EN(cfg_vreg_en), .CFG_SLOW(cfg_slow),
        .CFG_INP_DIS(cfg_inp_dis), .CFG_HLD_OVR(cfg_hld_ovr), .CFG_DONE(b_cfg_done),
        .CORE_OUT(core_out), .CORE_OE(core_oe), .IN(in_pad), .IN_SYNC(b_in_sync),
        .IN_RISE(b_in_rise), .IN_FALL(b_in_fall), .DM0(b_dm0), .DM1(b_dm1), .OUT(b_out),
        .OE_N(b_oe_n), .HLD_H_N(b_hld_h_n), .HLD_OVR(b_hld_ovr), .VTRIP_SEL(b_vtrip_sel),
        .IBUF_SEL(b_ibuf_sel), .VREG_EN(b_vreg_en), .SLOW(b_slow), .INP_DIS(b_inp_dis)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // bits = {vtrip_sel, ibuf_sel, vreg_en, slow, inp_dis, hld_ovr}
    task automatic set_cfg(input logic sel, input logic [2:0] dm, input logic [5:0] bits);
        cfg_sel       = sel;
        cfg_dm        = dm;
        cfg_vtrip_sel = bits[5];
        cfg_ibuf_sel  = bits[4];
        cfg_vreg_en   = bits[3];
        cfg_slow      = bits[2];
        cfg_inp_dis   = bits[1];
        cfg_hld_ovr   = bits[0];
    endtask

    task automatic do_config(input logic sel, input logic [2:0] dm, input logic [5:0] bits);
        int  n;
        bit  accepted;
        bit  finished;
        logic r;
        set_cfg(sel, dm, bits);
        cfg_valid = 1'b1;
        accepted  = 1'b0;
        finished  = 1'b0;
        n = 0;
        while (!accepted && n < 40) begin
            r = cfg_ready;
            tick();
            if (r) accepted = 1'b1;
            n++;
        end
        cfg_valid = 1'b0;
        n = 0;
        while (accepted && !finished && n < 40) begin
            tick();
            if (cfg_ready) finished = 1'b1;
            n++;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL config_timeout got accepted=%0b finished=%0b want 1 1", accepted, finished);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cfg_valid = 1'b1;
        set_cfg(1'b1, 3'b111, 6'b111111);
        in_pad = 2'b11; core_out = 2'b11; core_oe = 2'b11;
        tick();
        tick();
        checks++; if (oe_n !== 2'b11) begin errors++; $display("FAIL reset_oe_n got %b want 11", oe_n); end
        checks++; if (out !== 2'b00) begin errors++; $display("FAIL reset_out got %b want 00", out); end
        checks++; if (dm0 !== 3'b000 || dm1 !== 3'b000) begin errors++; $display("FAIL reset_dm got %b/%b want 000/000", dm0, dm1); end
        checks++; if (hld_h_n !== 2'b11) begin errors++; $display("FAIL reset_hld_h_n got %b want 11", hld_h_n); end
        checks++; if (inp_dis !== 2'b11) begin errors++; $display("FAIL reset_inp_dis got %b want 11", inp_dis); end
        checks++; if (cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin errors++; $display("FAIL reset_handshake got ready=%b done=%b want 1 0", cfg_ready, cfg_done); end
        checks++; if (in_rise !== 2'b00 || in_fall !== 2'b00 || in_sync !== 2'b00) begin errors++; $display("FAIL reset_inputs got sync=%b rise=%b fall=%b want 00", in_sync, in_rise, in_fall); end
        checks++; if (b_hld_h_n !== 2'b11 || b_oe_n !== 2'b11 || b_cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_b got hld=%b oe_n=%b ready=%b want 11 11 1", b_hld_h_n, b_oe_n, b_cfg_ready); end
        reset = 1'b0;
        cfg_valid = 1'b0;
        in_pad = 2'b00; core_out = 2'b00;
    endtask

    task automatic test_config_pad1;
        logic [1:0] drv;
        logic       pre1;
        logic       exp_hld1, exp_done, exp_rdy, exp_out1;
        logic [2:0] exp_dm1;
        core_oe = 2'b11; core_out = 2'b00;
        tick(); tick();
        set_cfg(1'b1, 3'b110, 6'b110101);
        cfg_valid = 1'b1;
        core_out = 2'b10;
        drv = core_out;
        tick();
        cfg_valid = 1'b0;
        pre1 = drv[1];
        checks++; if (cfg_ready !== 1'b0 || hld_h_n !== 2'b11 || out !== 2'b10) begin errors++; $display("FAIL cfg_accept got ready=%b hld=%b out=%b want 0 11 10", cfg_ready, hld_h_n, out); end
        for (int k = 1; k <= 16; k++) begin
            core_out[1] = ~core_out[1];
            core_out[0] = k[0];
            drv = core_out;
            tick();
            exp_hld1 = (k > 13);
            exp_done = (k == 14);
            exp_rdy  = (k >= 15);
            exp_dm1  = (k >= 6) ? 3'b110 : 3'b000;
            exp_out1 = (k <= 14) ? pre1 : drv[1];
            checks++; if (hld_h_n !== {exp_hld1, 1'b1}) begin errors++; $display("FAIL cfg_hld_h_n k=%0d got %b want %b", k, hld_h_n, {exp_hld1, 1'b1}); end
            checks++; if (cfg_done !== exp_done) begin errors++; $display("FAIL cfg_done k=%0d got %b want %b", k, cfg_done, exp_done); end
            checks++; if (cfg_ready !== exp_rdy) begin errors++; $display("FAIL cfg_ready k=%0d got %b want %b", k, cfg_ready, exp_rdy); end
            checks++; if (dm1 !== exp_dm1 || dm0 !== 3'b000) begin errors++; $display("FAIL cfg_dm k=%0d got %b/%b want %b/000", k, dm1, dm0, exp_dm1); end
            checks++; if (out !== {exp_out1, drv[0]}) begin errors++; $display("FAIL freeze_out k=%0d got %b want %b", k, out, {exp_out1, drv[0]}); end
            checks++; if (oe_n !== 2'b00) begin errors++; $display("FAIL freeze_oe_n k=%0d got %b want 00", k, oe_n); end
        end
        checks++; if (vtrip_sel !== 2'b10 || ibuf_sel !== 2'b10 || vreg_en !== 2'b00) begin errors++; $display("FAIL cfg_bits_a got %b %b %b want 10 10 00", vtrip_sel, ibuf_sel, vreg_en); end
        checks++; if (slow !== 2'b10 || inp_dis !== 2'b01 || hld_ovr !== 2'b10) begin errors++; $display("FAIL cfg_bits_b got %b %b %b want 10 01 10", slow, inp_dis, hld_ovr); end
    endtask

    task automatic test_input_edges;
        logic exp_sync, exp_edge;
        in_pad = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (in_sync !== 2'b00 || in_rise !== 2'b00) begin errors++; $display("FAIL in_disabled k=%0d got sync=%b rise=%b want 00 00", k, in_sync, in_rise); end
        end
        in_pad = 2'b00;
        tick(); tick(); tick();
        do_config(1'b0, 3'b011, 6'b000000);
        checks++; if (inp_dis !== 2'b00 || dm0 !== 3'b011) begin errors++; $display("FAIL cfg_pad0 got inp_dis=%b dm0=%b want 00 011", inp_dis, dm0); end
        tick(); tick();
        in_pad = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_sync = (k >= 2);
            exp_edge = (k == 3);
            checks++; if (in_sync !== {2{exp_sync}} || in_rise !== {2{exp_edge}} || in_fall !== 2'b00) begin errors++; $display("FAIL in_rise k=%0d got sync=%b rise=%b fall=%b want %b %b 00", k, in_sync, in_rise, in_fall, {2{exp_sync}}, {2{exp_edge}}); end
        end
        in_pad = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_sync = (k < 2);
            exp_edge = (k == 3);
            checks++; if (in_sync !== {2{exp_sync}} || in_fall !== {2{exp_edge}} || in_rise !== 2'b00) begin errors++; $display("FAIL in_fall k=%0d got sync=%b fall=%b rise=%b want %b %b 00", k, in_sync, in_fall, in_rise, {2{exp_sync}}, {2{exp_edge}}); end
        end
    endtask

    task automatic test_reset_mid;
        set_cfg(1'b0, 3'b101, 6'b000000);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                checks++; if (dm0 !== 3'b101) begin errors++; $display("FAIL mid_apply got dm0=%b want 101", dm0); end
            end
        end
        checks++; if (hld_h_n !== 2'b10) begin errors++; $display("FAIL mid_settle_hold got %b want 10", hld_h_n); end
        reset = 1'b1;
        tick();
        checks++; if (hld_h_n !== 2'b11 || dm0 !== 3'b000 || dm1 !== 3'b000) begin errors++; $display("FAIL mid_reset got hld=%b dm0=%b dm1=%b want 11 000 000", hld_h_n, dm0, dm1); end
        checks++; if (cfg_ready !== 1'b1 || cfg_done !== 1'b0 || oe_n !== 2'b11 || inp_dis !== 2'b11) begin errors++; $display("FAIL mid_reset_state got ready=%b done=%b oe_n=%b inp_dis=%b want 1 0 11 11", cfg_ready, cfg_done, oe_n, inp_dis); end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_no_done k=%0d got done=%b ready=%b want 0 1", k, cfg_done, cfg_ready); end
        end
    endtask

    task automatic test_back_to_back;
        int   hs, hs1, nd, d1, d2, both_low;
        logic v, r;
        hs = 0; hs1 = -1; nd = 0; d1 = -1; d2 = -1; both_low = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_cfg(1'b0, 3'b001, 6'b000000);
        cfg_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            v = cfg_valid;
            r = b_cfg_ready;
            tick();
            if (v && r) begin
                hs++;
                if (hs == 1) begin
                    hs1 = c;
                    set_cfg(1'b1, 3'b010, 6'b000000);
                end else begin
                    cfg_valid = 1'b0;
                end
            end
            if (b_cfg_done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = c;
                else d2 = c;
            end
            if (b_hld_h_n === 2'b00) both_low++;
        end
        cfg_valid = 1'b0;
        checks++; if (hs != 2) begin errors++; $display("FAIL b2b_handshakes got %0d want 2", hs); end
        checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        checks++; if (d1 - hs1 != 4) begin errors++; $display("FAIL b2b_first_latency got %0d want 4", d1 - hs1); end
        checks++; if (d2 - d1 != 6) begin errors++; $display("FAIL b2b_spacing got %0d want 6", d2 - d1); end
        checks++; if (both_low != 0) begin errors++; $display("FAIL b2b_both_hold got %0d cycles want 0", both_low); end
        checks++; if (b_dm0 !== 3'b001 || b_dm1 !== 3'b010) begin errors++; $display("FAIL b2b_dm got %b/%b want 001/010", b_dm0, b_dm1); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_config_pad1();
        test_input_edges();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
